b14_bus_arb: RTL and testbench
==============================

B14_BUS_ARB -- requirements
Module: b14_bus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum cycles an access waits for mem_ready before it aborts (legal 1..255).
REQ-002 SHALL have parameter ADDR_W, default 20, the address width.
REQ-003 SHALL have parameter DATA_W, default 31, the data width.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rd0 / wr0  in  1 each  requester 0 read / write request; level, held until ack0.
REQ-007 addr0  in  ADDR_W  requester 0 address.
REQ-008 wdata0  in  DATA_W  requester 0 write data.
REQ-009 rd1, wr1, addr1, wdata1  in  same widths  requester 1 equivalents of REQ-006..REQ-008.
REQ-010 ack0 / ack1  out  1 each  one-cycle completion pulse.
REQ-011 err0 / err1  out  1 each  one-cycle timeout pulse, coincident with ack.
REQ-012 rdata0 / rdata1  out  DATA_W each  read data, valid while ack is high, held until the next ack.
REQ-013 gnt  out  2  one-hot owner of the memory port, 00 when idle.
REQ-014 mem_addr  out  ADDR_W  memory address.
REQ-015 mem_wdata  out  DATA_W  memory write data.
REQ-016 mem_rd / mem_wr  out  1 each  memory read / write strobes.
REQ-017 mem_rdata  in  DATA_W  memory read data.
REQ-018 mem_ready  in  1  memory completion.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-020 IDLE: a requester is pending when rdN|wrN; none pending -> stay in IDLE.
REQ-021 IDLE, exactly one requester pending: grant it, latch its addr, wdata and op, and go to ACCESS.
REQ-022 IDLE, both pending: grant the requester not granted last (round-robin); last-grant register resets to 1, so requester 0 wins the first tie.
REQ-023 If rdN and wrN are both high, SHALL perform a write and ignore rd.
REQ-024 ACCESS: mem_rd or mem_wr SHALL be high, mem_addr and mem_wdata SHALL hold the latched values, gnt SHALL be one-hot, and the wait counter SHALL increment each cycle from 0.
REQ-025 ACCESS, mem_ready=1: capture mem_rdata into rdataN (reads only), go to DONE.
REQ-026 ACCESS, mem_ready=0 with counter = TIMEOUT-1: abort, set rdataN=0 on reads, set error flag, go to DONE.
REQ-027 DONE: ackN=1 for exactly one cycle (errN=1 if aborted), strobes low, gnt still set, requests ignored; next state IDLE.
REQ-028 Latency: request seen at edge k -> strobe from cycle k+1; mem_ready at edge j -> ack in cycle j+1; minimum request-to-ack is 3 cycles.
REQ-029 mem_ready while not in ACCESS SHALL be ignored.
REQ-030 mem_rd and mem_wr SHALL never be high together; ack0 and ack1 SHALL never be high together.
REQ-031 The non-granted requester's inputs SHALL have no effect until the next IDLE.

Reset
REQ-032 Reset SHALL force IDLE, counter 0, last-grant 1, and all outputs 0 (ack, err, rdata, gnt, mem_*).
REQ-033 Reset mid-ACCESS or mid-DONE SHALL drop the strobes in the next cycle and produce no ack.

Structure
REQ-034 A shared package SHALL hold the state enum, ADDR_W/DATA_W defaults and the TIMEOUT default.
REQ-035 The block SHALL be a single module with no sub-module; counter width is $clog2(TIMEOUT+1).

Verification
REQ-036 Single read: rd0=1, addr0=0x00010, mem_ready one cycle after strobe with mem_rdata=0x1234567 -> ack0 pulse, rdata0=0x1234567, gnt=01 during access.
REQ-037 Contention: rd0 and wr1 raised the same cycle after reset -> requester 0 served first, then requester 1 with mem_wr=1 and mem_wdata=wdata1; gnt sequence 01 then 10.
REQ-038 Fairness: both requesters re-request continuously for 6 accesses -> grants alternate 0,1,0,1,0,1.
REQ-039 Timeout: wr1, mem_ready held 0, TIMEOUT=15 -> strobe high 15 cycles, then ack1=err1=1 for one cycle and the FSM returns to IDLE.
REQ-040 Reset mid-access: reset asserted in the 3rd ACCESS cycle -> next cycle all outputs 0, no ack; a following rd1 completes normally.
REQ-041 rd0=wr0=1 -> only mem_wr asserted; rdata0 unchanged.

Source files
------------

// File: rtl/b14_bus_arb_pkg.sv
// Shared types and parameter defaults for the two-requester memory bus arbiter.
package b14_bus_arb_pkg;

  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned ADDR_W_DEF  = 20;
  localparam int unsigned DATA_W_DEF  = 31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/b14_bus_arb.sv
// Round-robin arbiter giving two requesters access to one memory port, with a
// per-access ready timeout. Every output comes straight from a flop.
module b14_bus_arb
  import b14_bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              rd1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;    // requester granted most recently
  logic              sel_q, sel_d;      // requester owning the current access
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              pend0_c, pend1_c, pick_c;

  // Next-state and next-output logic: arbitrate in IDLE, wait for ready or timeout in ACCESS.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    sel_d    = sel_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt_d    = gnt_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    pend0_c  = rd0 | wr0;
    pend1_c  = rd1 | wr1;
    pick_c   = (pend0_c & pend1_c) ? ~last_q : pend1_c;

    case (state_q)
      ST_IDLE: begin
        gnt_d = 2'b00;
        if (pend0_c | pend1_c) begin
          state_d  = ST_ACCESS;
          cnt_d    = '0;
          last_d   = pick_c;
          sel_d    = pick_c;
          op_wr_d  = pick_c ? wr1 : wr0;
          addr_d   = pick_c ? addr1 : addr0;
          wdata_d  = pick_c ? wdata1 : wdata0;
          gnt_d    = pick_c ? 2'b10 : 2'b01;
          mem_wr_d = op_wr_d;
          mem_rd_d = ~op_wr_d;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ready || (cnt_q == CNT_LAST)) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          ack0_d   = ~sel_q;
          ack1_d   = sel_q;
          err0_d   = ~mem_ready & ~sel_q;
          err1_d   = ~mem_ready & sel_q;
          if (!op_wr_q) begin
            if (sel_q) rdata1_d = mem_ready ? mem_rdata : '0;
            else       rdata0_d = mem_ready ? mem_rdata : '0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = 2'b00;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= 2'b00;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign gnt       = gnt_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_b14_bus_arb.sv
// Self-checking bench for b14_bus_arb: table of request rounds, a memory
// responder, and a scoreboard of expected completions.
module tb_b14_bus_arb;
  import b14_bus_arb_pkg::*;

  localparam int unsigned TO    = 15;
  localparam int unsigned AW    = 20;
  localparam int unsigned DW    = 31;
  localparam int unsigned NEVER = 99;
  localparam int unsigned NVEC  = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          rd0, wr0, rd1, wr1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic          ack0, ack1, err0, err1, mem_rd, mem_wr, mem_ready;
  logic [1:0]    gnt;

  always #5 clock = ~clock;

  b14_bus_arb #(.TIMEOUT(TO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .gnt(gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // One round: request lines raised together; memory answers `lat` cycles into each access.
  typedef struct {
    logic          rd0, wr0, rd1, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] mrdata;
    int unsigned   lat;
    bit            hold;
    int unsigned   nacc;
  } vec_t;

  typedef struct {
    int unsigned   idx;
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int unsigned   strobes;
  } exp_t;

  exp_t          sb[$];
  vec_t          vecs[NVEC];
  int unsigned   last_exp;
  logic [DW-1:0] rd_exp[2];
  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;

  function automatic vec_t mk(input logic r0, input logic w0, input logic r1, input logic w1,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [DW-1:0] m, input int unsigned lat,
                              input bit hold, input int unsigned nacc);
    vec_t v;
    v.rd0 = r0; v.wr0 = w0; v.rd1 = r1; v.wr1 = w1;
    v.addr0 = a0; v.addr1 = a1; v.wdata0 = d0; v.wdata1 = d1;
    v.mrdata = m; v.lat = lat; v.hold = hold; v.nacc = nacc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ctrl"}, 64'({ack0, ack1, err0, err1, mem_rd, mem_wr, gnt}), 64'd0);
    chk({tag, " rdata0"}, 64'(rdata0), 64'd0);
    chk({tag, " rdata1"}, 64'(rdata1), 64'd0);
    chk({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // Predict service order (round-robin from the model's last grant) and results.
  task automatic push_expected(input vec_t v);
    bit p0, p1;
    int unsigned n;
    p0 = v.rd0 | v.wr0;
    p1 = v.rd1 | v.wr1;
    n  = v.hold ? v.nacc : (32'(p0) + 32'(p1));
    for (int i = 0; i < int'(n); i++) begin
      int unsigned pick;
      exp_t e;
      if (p0 && p1) pick = 1 - last_exp;
      else          pick = p1 ? 1 : 0;
      last_exp = pick;
      if (!v.hold) begin
        if (pick == 0) p0 = 1'b0; else p1 = 1'b0;
      end
      e.idx     = pick;
      e.is_wr   = (pick == 0) ? v.wr0 : v.wr1;
      e.addr    = (pick == 0) ? v.addr0 : v.addr1;
      e.wdata   = (pick == 0) ? v.wdata0 : v.wdata1;
      e.err     = (v.lat >= TO);
      e.strobes = e.err ? TO : v.lat + 1;
      if (!e.is_wr) rd_exp[pick] = e.err ? '0 : DW'(v.mrdata + DW'(i));
      e.rdata   = rd_exp[pick];
      sb.push_back(e);
    end
  endtask

  task automatic run_vector(input vec_t v, input string name);
    int unsigned acc_n, acc_idx, cyc;
    exp_t e;
    push_expected(v);
    rd0 = v.rd0; wr0 = v.wr0; rd1 = v.rd1; wr1 = v.wr1;
    addr0 = v.addr0; addr1 = v.addr1; wdata0 = v.wdata0; wdata1 = v.wdata1;
    acc_n = 0; acc_idx = 0; cyc = 0;
    while (sb.size() != 0 && cyc < 400) begin
      @(negedge clock);
      cyc++;
      chk({name, " rd/wr exclusive"}, 64'(mem_rd & mem_wr), 64'd0);
      if (ack0 | ack1) begin
        e = sb.pop_front();
        chk({name, " ack"}, 64'({ack0, ack1}), (e.idx == 0) ? 64'd2 : 64'd1);
        chk({name, " err"}, 64'({err0, err1}), e.err ? ((e.idx == 0) ? 64'd2 : 64'd1) : 64'd0);
        chk({name, " rdata"}, 64'((e.idx == 0) ? rdata0 : rdata1), 64'(e.rdata));
        chk({name, " strobe cycles"}, 64'(acc_n), 64'(e.strobes));
        chk({name, " done strobes low / gnt held"}, 64'({mem_rd, mem_wr, gnt}),
            64'((e.idx == 0) ? 2'b01 : 2'b10));
        if (v.hold) begin
          if (acc_idx + 1 == v.nacc) begin rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0; end
        end else if (e.idx == 0) begin
          rd0 = 0; wr0 = 0;
        end else begin
          rd1 = 0; wr1 = 0;
        end
        acc_idx++;
        acc_n = 0;
        mem_ready = 1'($urandom_range(0, 1));
      end else if (mem_rd | mem_wr) begin
        if (acc_n == 0) begin
          e = sb[0];
          if (acc_idx == 0) chk({name, " req-to-strobe latency"}, 64'(cyc), 64'd1);
          chk({name, " gnt"}, 64'(gnt), 64'((e.idx == 0) ? 2'b01 : 2'b10));
          chk({name, " op"}, 64'({mem_rd, mem_wr}), e.is_wr ? 64'd1 : 64'd2);
          chk({name, " mem_addr"}, 64'(mem_addr), 64'(e.addr));
          chk({name, " mem_wdata"}, 64'(mem_wdata), 64'(e.wdata));
        end
        mem_ready = (acc_n == v.lat);
        mem_rdata = DW'(v.mrdata + DW'(acc_idx));
        acc_n++;
      end else begin
        chk({name, " idle gnt/err"}, 64'({gnt, err0, err1}), 64'd0);
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: completions missing, got %0d outstanding expected 0", name, sb.size());
      sb.delete();
    end
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    @(negedge clock);
  endtask

  initial begin
    int unsigned n;
    vecs[0] = mk(1, 0, 0, 1, 20'h00010, 20'h0ABCD, 31'h0, 31'h5A5A5A5, 31'h1234567, 1, 0, 0);
    vecs[1] = mk(1, 0, 0, 0, 20'h00010, 20'h0, 31'h0, 31'h0, 31'h1234567, 1, 0, 0);
    vecs[2] = mk(0, 0, 1, 0, 20'h0, 20'hFFFFF, 31'h0, 31'h0, 31'h7FFFFFFF, 0, 0, 0);
    vecs[3] = mk(0, 1, 0, 0, 20'h12345, 20'h0, 31'h0000001, 31'h0, 31'h0, 3, 0, 0);
    vecs[4] = mk(1, 1, 0, 0, 20'h54321, 20'h0, 31'h2AAAAAA, 31'h0, 31'h6666666, 2, 0, 0);
    vecs[5] = mk(0, 0, 0, 1, 20'h0, 20'hA0A0A, 31'h0, 31'h3C3C3C3, 31'h0, NEVER, 0, 0);
    vecs[6] = mk(1, 0, 0, 0, 20'h00F0F, 20'h0, 31'h0, 31'h0, 31'h0DEF000, TO - 1, 0, 0);
    vecs[7] = mk(0, 0, 1, 0, 20'h0, 20'h77777, 31'h0, 31'h0, 31'h1111111, TO, 0, 0);
    vecs[8] = mk(1, 0, 1, 0, 20'h00100, 20'h00200, 31'h0, 31'h0, 31'h0000100, 0, 1, 6);
    vecs[9] = mk(0, 1, 1, 0, 20'h3FFFF, 20'h40000, 31'h4545454, 31'h0, 31'h7070707, 2, 0, 0);

    reset = 1; rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_rdata = '0; mem_ready = 0;
    last_exp = 1; rd_exp[0] = '0; rd_exp[1] = '0;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset = 0;
    @(negedge clock);
    check_zero("idle after reset");

    for (int i = 0; i < int'(NVEC); i++) run_vector(vecs[i], $sformatf("v%0d", i));

    // Reset during the third ACCESS cycle: outputs clear next cycle, no ack.
    rd0 = 1; addr0 = 20'h00ABC; mem_ready = 0; n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clock);
      if (mem_rd | mem_wr) n++;
    end
    chk("rst_mid third access cycle reached", 64'(n), 64'd3);
    reset = 1; rd0 = 0;
    @(negedge clock);
    check_zero("rst_mid");
    reset = 0;
    @(negedge clock);
    check_zero("rst_mid idle");
    last_exp = 1; rd_exp[0] = '0; rd_exp[1] = '0;
    run_vector(mk(0, 0, 1, 0, 20'h0, 20'h0BEEF, 31'h0, 31'h0, 31'h2468ACE, 1, 0, 0), "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
